// File: rtl/decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decoder_pkg
// Description : Shared types, constants and helpers for decoder_scan.
//               - dec_state_t : controller states (S_IDLE, S_HOLD, S_SCAN)
//               - MODE_DIRECT / MODE_SCAN : values of the mode input
//               - onehot()    : wide one-hot helper, all zeros when code >= n
// Revision    : 1.0 - initial release
// ============================================================================
package decoder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_SCAN = 2'd2
  } dec_state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Widest supported select bank; callers truncate to their own width.
  localparam int unsigned ONEHOT_MAX = 256;

  function automatic logic [ONEHOT_MAX-1:0] onehot(input logic [7:0] code,
                                                   input int unsigned n);
    logic [ONEHOT_MAX-1:0] r;
    r = '0;
    if ({24'd0, code} < n) r[code] = 1'b1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/scan_divider.sv
`default_nettype none
// ============================================================================
// Module      : scan_divider
// Description : Modulo-SCAN_DIV step counter for the scan walker.
//               Counts 0..SCAN_DIV-1; at terminal count it wraps to 0 unless
//               hold is high, in which case it parks on terminal.
// Ports       : clk, rst_n  - clock, asynchronous active-low reset
//               clear       - force count to 0 (scan not running)
//               hold        - stall at terminal count
//               tc          - count is at SCAN_DIV-1
// Revision    : 1.0 - initial release
// ============================================================================
module scan_divider #(
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic hold,
  output logic tc
);

  // A one-cycle divider still needs a 1-bit register; it simply stays at 0.
  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tc) begin
      if (!hold) count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == LAST);

endmodule
`default_nettype wire

// File: rtl/decoder_scan.sv
`default_nettype none
// ============================================================================
// Module      : decoder_scan
// Description : One-hot decoder with registered output, valid/ready handshake
//               and an autonomous scan mode that walks the select lines.
//               Optional macro DECODER_RANGE_CHECK_EN enables the err pulse
//               for accepted out-of-range codes; otherwise err is tied 0.
// Ports       : clk, rst_n            - clock, async active-low reset
//               mode                  - 0 direct decode, 1 scan
//               in_valid/in_ready/in  - code input handshake
//               out                   - registered select lines
//               out_valid/out_ready   - output handshake / scan advance
//               cur_code              - code currently driving out
//               err                   - out-of-range pulse
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int unsigned NUM_OUT    = 8,
  parameter int unsigned SCAN_DIV   = 4,
  parameter int unsigned ACTIVE_LOW = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       mode,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [$clog2(NUM_OUT)-1:0] in,
  output logic [NUM_OUT-1:0]         out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(NUM_OUT)-1:0] cur_code,
  output logic                       err
);

  localparam int unsigned W = $clog2(NUM_OUT);
  localparam logic [W-1:0] LAST_CODE = W'(NUM_OUT - 1);

  dec_state_t         state;
  logic [NUM_OUT-1:0] sel;        // active-high selection, inverted at the pins
  logic               accept;
  logic               scan_active;
  logic               tc;
  logic [W-1:0]       next_scan;

  assign out_valid   = (state != S_IDLE);
  assign scan_active = (state == S_SCAN) && (mode == MODE_SCAN);

  // While the scan is still running (mode just dropped) nothing is accepted;
  // the block first falls back to S_IDLE.
  assign in_ready = (mode == MODE_DIRECT) && (state != S_SCAN) &&
                    ((state == S_IDLE) || out_ready);
  assign accept   = in_valid && in_ready;

  assign next_scan = (cur_code == LAST_CODE) ? '0 : cur_code + 1'b1;

  scan_divider #(
    .SCAN_DIV (SCAN_DIV)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (!scan_active),
    .hold  (!out_ready),
    .tc    (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      sel      <= '0;
      cur_code <= '0;
    end else if (mode == MODE_SCAN) begin
      if (state != S_SCAN) begin
        // Entering scan discards any pending direct selection.
        state    <= S_SCAN;
        cur_code <= '0;
        sel      <= NUM_OUT'(onehot(8'd0, NUM_OUT));
      end else if (tc && out_ready) begin
        cur_code <= next_scan;
        sel      <= NUM_OUT'(onehot(8'(next_scan), NUM_OUT));
      end
    end else if (state == S_SCAN) begin
      state <= S_IDLE;
      sel   <= '0;
    end else if (accept) begin
      // Out-of-range codes load an all-inactive pattern but still hold.
      state    <= S_HOLD;
      cur_code <= in;
      sel      <= NUM_OUT'(onehot(8'(in), NUM_OUT));
    end else if ((state == S_HOLD) && out_ready) begin
      state <= S_IDLE;
      sel   <= '0;
    end
  end

  generate
    if (ACTIVE_LOW != 0) begin : g_active_low
      assign out = ~sel;
    end else begin : g_active_high
      assign out = sel;
    end
  endgenerate

`ifdef DECODER_RANGE_CHECK_EN
  logic code_oor;
  logic err_q;

  assign code_oor = ({1'b0, in} >= (W + 1)'(NUM_OUT));

  // Registered alongside the selection so the pulse lines up with out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= accept && code_oor;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_decoder_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_decoder_scan
// Description : Self-checking bench for decoder_scan. Three instances share
//               stimulus: 8 lines / div 4 / active-high, 5 lines / div 3 /
//               active-high, 6 lines / div 1 / active-low. A behavioural
//               model tracks each instance and is compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_scan;

`ifdef DECODER_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode;
  logic       in_valid;
  logic       out_ready;
  logic [2:0] in_code;

  logic [7:0] out8;
  logic [4:0] out5;
  logic [5:0] out6;
  logic [2:0] ovld, irdy, erv;
  logic [2:0] cc8, cc5, cc6;

  int  checks = 0;
  int  errors = 0;
  bit  sb_en  = 1'b0;

  always #5 clk = ~clk;

  decoder_scan #(.NUM_OUT(8), .SCAN_DIV(4), .ACTIVE_LOW(0)) u_d8 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(irdy[0]),
    .in(in_code), .out(out8), .out_valid(ovld[0]), .out_ready(out_ready),
    .cur_code(cc8), .err(erv[0]));

  decoder_scan #(.NUM_OUT(5), .SCAN_DIV(3), .ACTIVE_LOW(0)) u_d5 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(irdy[1]),
    .in(in_code), .out(out5), .out_valid(ovld[1]), .out_ready(out_ready),
    .cur_code(cc5), .err(erv[1]));

  decoder_scan #(.NUM_OUT(6), .SCAN_DIV(1), .ACTIVE_LOW(1)) u_d6 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(irdy[2]),
    .in(in_code), .out(out6), .out_valid(ovld[2]), .out_ready(out_ready),
    .cur_code(cc6), .err(erv[2]));

  function automatic int n_of(input int i);
    case (i) 0: return 8; 1: return 5; default: return 6; endcase
  endfunction
  function automatic int div_of(input int i);
    case (i) 0: return 4; 1: return 3; default: return 1; endcase
  endfunction
  function automatic bit al_of(input int i);
    return (i == 2);
  endfunction

  function automatic logic [7:0] act_out(input int i);
    case (i) 0: return out8; 1: return {3'b000, out5}; default: return {2'b00, out6}; endcase
  endfunction
  function automatic logic [2:0] act_cc(input int i);
    case (i) 0: return cc8; 1: return cc5; default: return cc6; endcase
  endfunction

  // ---------------- reference model ----------------
  bit m_valid [3];
  bit m_scan  [3];
  bit m_err   [3];
  int m_code  [3];
  int m_age   [3];   // cycles the current scan code has already been shown

  function automatic bit m_ready(input int i);
    return !mode && !m_scan[i] && (!m_valid[i] || out_ready);
  endfunction

  function automatic logic [7:0] exp_out(input int i);
    logic [7:0] r;
    int mask;
    r = 8'h00;
    if (m_valid[i] && m_code[i] < n_of(i)) r[m_code[i]] = 1'b1;
    if (al_of(i)) begin
      mask = (1 << n_of(i)) - 1;
      r = ~r & mask[7:0];
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_valid[i] <= 1'b0; m_scan[i] <= 1'b0; m_err[i] <= 1'b0;
        m_code[i]  <= 0;    m_age[i]  <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        m_err[i] <= 1'b0;
        if (mode) begin
          if (!m_scan[i]) begin
            m_scan[i] <= 1'b1; m_valid[i] <= 1'b1; m_code[i] <= 0; m_age[i] <= 0;
          end else if (m_age[i] < div_of(i) - 1) begin
            m_age[i] <= m_age[i] + 1;
          end else if (out_ready) begin
            m_code[i] <= (m_code[i] + 1) % n_of(i);
            m_age[i]  <= 0;
          end
        end else if (m_scan[i]) begin
          m_scan[i] <= 1'b0; m_valid[i] <= 1'b0;
        end else if (in_valid && m_ready(i)) begin
          m_valid[i] <= 1'b1;
          m_code[i]  <= int'(in_code);
          m_err[i]   <= RC && (int'(in_code) >= n_of(i));
        end else if (m_valid[i] && out_ready) begin
          m_valid[i] <= 1'b0;
        end
      end
    end
  end

  // ---------------- per-cycle scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && sb_en) begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (act_out(i) !== exp_out(i)) begin
          errors++; $display("FAIL sb_out[%0d] t=%0t got %h exp %h", i, $time, act_out(i), exp_out(i));
        end
        checks++;
        if (ovld[i] !== m_valid[i]) begin
          errors++; $display("FAIL sb_out_valid[%0d] t=%0t got %b exp %b", i, $time, ovld[i], m_valid[i]);
        end
        checks++;
        if (irdy[i] !== m_ready(i)) begin
          errors++; $display("FAIL sb_in_ready[%0d] t=%0t got %b exp %b", i, $time, irdy[i], m_ready(i));
        end
        checks++;
        if (act_cc(i) !== 3'(m_code[i])) begin
          errors++; $display("FAIL sb_cur_code[%0d] t=%0t got %0d exp %0d", i, $time, act_cc(i), m_code[i]);
        end
        checks++;
        if (erv[i] !== m_err[i]) begin
          errors++; $display("FAIL sb_err[%0d] t=%0t got %b exp %b", i, $time, erv[i], m_err[i]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out8 !== 8'h00 || out5 !== 5'h00 || out6 !== 6'h3f) begin
      errors++; $display("FAIL reset_out got %h %h %h exp 00 00 3f", out8, out5, out6);
    end
    checks++;
    if (ovld !== 3'b000 || erv !== 3'b000 || irdy !== 3'b111) begin
      errors++; $display("FAIL reset_flags got v=%b e=%b r=%b exp v=000 e=000 r=111", ovld, erv, irdy);
    end
    checks++;
    if (cc8 !== 3'd0 || cc5 !== 3'd0 || cc6 !== 3'd0) begin
      errors++; $display("FAIL reset_cur_code got %0d %0d %0d exp 0 0 0", cc8, cc5, cc6);
    end
    rst_n = 1'b1;
    sb_en = 1'b1;
  endtask

  task automatic test_direct();
    in_code = 3'd5; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (out8 !== 8'b0010_0000 || ovld[0] !== 1'b1 || cc8 !== 3'd5) begin
      errors++; $display("FAIL direct_5 got out=%b v=%b cc=%0d exp out=00100000 v=1 cc=5", out8, ovld[0], cc8);
    end
    checks++;
    if (out5 !== 5'b00000 || ovld[1] !== 1'b1 || erv[1] !== RC) begin
      errors++; $display("FAIL direct_oor5 got out=%b v=%b err=%b exp out=00000 v=1 err=%b", out5, ovld[1], erv[1], RC);
    end
    tick();
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; in_code = 3'd3;
    tick();
    in_code = 3'd6;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (irdy[0] !== 1'b0 || out8 !== 8'b0000_1000) begin
        errors++; $display("FAIL bp_hold got r=%b out=%b exp r=0 out=00001000", irdy[0], out8);
      end
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (irdy[0] !== 1'b1) begin
      errors++; $display("FAIL bp_release got r=%b exp r=1", irdy[0]);
    end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out8 !== 8'b0100_0000 || cc8 !== 3'd6) begin
      errors++; $display("FAIL bp_code6 got out=%b cc=%0d exp out=01000000 cc=6", out8, cc8);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    logic [2:0] c;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      c = 3'($urandom_range(0, 7));
      in_code = c;
      tick();
      @(negedge clk);
      e = 8'd1 << c;
      checks++;
      if (out8 !== e || ovld[0] !== 1'b1) begin
        errors++; $display("FAIL b2b[%0d] got out=%b v=%b exp out=%b v=1", k, out8, ovld[0], e);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_scan();
    int c;
    mode = 1'b1; out_ready = 1'b1;
    tick();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      c = (k / 3) % 5;
      checks++;
      if (cc5 !== 3'(c) || out5 !== 5'(1 << c)) begin
        errors++; $display("FAIL scan5[%0d] got cc=%0d out=%b exp cc=%0d", k, cc5, out5, c);
      end
      tick();
    end
  endtask

  task automatic test_scan_stall();
    int c;
    mode = 1'b0;
    tick();
    mode = 1'b1; out_ready = 1'b1;
    tick();
    for (int k = 0; k < 14; k++) begin
      if (k == 8)  out_ready = 1'b0;
      if (k == 12) out_ready = 1'b1;
      @(negedge clk);
      c = (k < 6) ? k / 3 : ((k <= 12) ? 2 : 3);
      checks++;
      if (cc5 !== 3'(c)) begin
        errors++; $display("FAIL stall5[%0d] got cc=%0d exp cc=%0d", k, cc5, c);
      end
      tick();
    end
  endtask

  task automatic test_range();
    mode = 1'b0; out_ready = 1'b1;
    tick();
    in_code = 3'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out6 !== 6'h3f || ovld[2] !== 1'b1 || cc6 !== 3'd7 || erv[2] !== RC) begin
      errors++; $display("FAIL range6 got out=%b v=%b cc=%0d err=%b exp out=111111 v=1 cc=7 err=%b",
                         out6, ovld[2], cc6, erv[2], RC);
    end
    tick();
    @(negedge clk);
    checks++;
    if (erv[2] !== 1'b0 || ovld[2] !== 1'b0) begin
      errors++; $display("FAIL range6_pulse got err=%b v=%b exp err=0 v=0", erv[2], ovld[2]);
    end
    tick();
  endtask

  task automatic test_async_reset();
    mode = 1'b1; out_ready = 1'b1;
    repeat (5) tick();
    #2;
    sb_en = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out6 !== 6'h3f || out8 !== 8'h00 || ovld !== 3'b000 || cc6 !== 3'd0) begin
      errors++; $display("FAIL async_rst got out6=%b out8=%b v=%b cc6=%0d exp 111111 00000000 000 0",
                         out6, out8, ovld, cc6);
    end
    mode = 1'b0;
    tick();
    rst_n = 1'b1;
    sb_en = 1'b1;
    in_code = 3'd0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out6 !== 6'b111110 || out8 !== 8'b0000_0001) begin
      errors++; $display("FAIL post_rst_code0 got out6=%b out8=%b exp 111110 00000001", out6, out8);
    end
    tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      in_valid  = 1'($urandom_range(0, 1));
      in_code   = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    mode = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; in_valid = 1'b0; in_code = 3'd0; out_ready = 1'b1;
    test_reset();
    test_direct();
    test_backpressure();
    test_back_to_back();
    test_scan();
    test_scan_stall();
    test_range();
    test_async_reset();
    test_random();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
